// File: rtl/hilo_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers.
// One radix-2 step per cycle on operand magnitudes, sign correction in a final FIX cycle.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic             busy_r;
  logic [CNT_W-1:0] cnt_r;
  logic             is_div_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic             div0_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] work_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;

  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_trial_s;
  logic               div_ok_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return (~x) + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return (~x) + (2*WIDTH)'(1);
  endfunction

  // Operand magnitudes and per-step arithmetic
  always_comb begin
    a_neg_s = (~op[0]) & in1[WIDTH-1];
    b_neg_s = (~op[0]) & in2[WIDTH-1];
    a_mag_s = a_neg_s ? neg_w(in1) : in1;
    b_mag_s = b_neg_s ? neg_w(in2) : in2;
    mul_sum_s = {1'b0, acc_r} + (work_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    div_trial_s = {acc_r, work_r[WIDTH-1]} - {1'b0, b_r};
    // A zero divisor always "fits", yielding all-ones quotient and the dividend as remainder
    div_ok_s = (~div_trial_s[WIDTH]) | div0_r;
  end

  // Sign correction applied in FIX
  always_comb begin
    prod_fix_s = neg_q_r ? neg_2w({acc_r, work_r}) : {acc_r, work_r};
    if (div0_r) begin
      quo_fix_s = {WIDTH{1'b1}};
    end else begin
      quo_fix_s = neg_q_r ? neg_w(work_r) : work_r;
    end
    rem_fix_s = neg_r_r ? neg_w(acc_r) : acc_r;
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      RUN: begin
        if (cnt_r == CNT_W'(WIDTH-1)) state_next_s = FIX;
        else                          state_next_s = RUN;
      end
      FIX:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register and registered busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
    end
  end

  // Datapath: launch, iterate, correct, and HI/LO moves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= '0;
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      div0_r   <= 1'b0;
      b_r      <= '0;
      acc_r    <= '0;
      work_r   <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r    <= '0;
            is_div_r <= op[1];
            neg_q_r  <= a_neg_s ^ b_neg_s;
            neg_r_r  <= a_neg_s;
            div0_r   <= op[1] & (in2 == '0);
            b_r      <= b_mag_s;
            acc_r    <= '0;
            work_r   <= a_mag_s;
          end else begin
            if (mthi) hi_r <= in1;
            if (mtlo) lo_r <= in1;
          end
        end
        RUN: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (is_div_r) begin
            if (div_ok_s) begin
              acc_r  <= div_trial_s[WIDTH-1:0];
              work_r <= {work_r[WIDTH-2:0], 1'b1};
            end else begin
              acc_r  <= {acc_r[WIDTH-2:0], work_r[WIDTH-1]};
              work_r <= {work_r[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_r  <= mul_sum_s[WIDTH:1];
            work_r <= {mul_sum_s[0], work_r[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (is_div_r) begin
            hi_r <= rem_fix_s;
            lo_r <= quo_fix_s;
          end else begin
            hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
            lo_r <= prod_fix_s[WIDTH-1:0];
          end
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit with hand-computed results.
module tb_hilo_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .in1   (in1),
    .in2   (in2),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Launch one operation, watch HI/LO hold during the run, then check latency and result.
  // With disturb set, mthi/mtlo accompany the start and a second start+mthi/mtlo is
  // pulsed mid-run; all of it must be ignored.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic disturb);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int n;
    old_hi = hi;
    old_lo = lo;
    op = o; in1 = a; in2 = b; start = 1'b1;
    mthi = disturb; mtlo = disturb;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    in1 = 32'hDEAD_BEEF; in2 = 32'h0000_0000; op = 2'b11;
    n = 0;
    while (busy && n < 40) begin
      if (disturb && n == 5) begin
        start = 1'b1; op = 2'b00; in1 = 32'h1234_5678; in2 = 32'h0000_0002;
        mthi = 1'b1; mtlo = 1'b1;
      end
      if (disturb && n == 8) begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      end
      if (n == 1 || n == 20) begin
        check_val({tag, "_hold_hi"}, hi, old_hi);
        check_val({tag, "_hold_lo"}, lo, old_lo);
      end
      @(posedge clk); #1;
      n++;
    end
    check_val({tag, "_cycles"}, 32'(n), 32'd33);
    check_val({tag, "_hi"}, hi, exp_hi);
    check_val({tag, "_lo"}, lo, exp_lo);
    check_val({tag, "_nox"}, {31'd0, $isunknown({hi, lo})}, 32'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; op = 2'b00;
    in1 = 32'h0; in2 = 32'h0; mthi = 1'b0; mtlo = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_hi", hi, 32'h0000_0000);
    check_val("rst_lo", lo, 32'h0000_0000);

    in1 = 32'hA5A5_A5A5; mthi = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0;
    check_val("mthi_hi", hi, 32'hA5A5_A5A5);
    check_val("mthi_lo", lo, 32'h0000_0000);

    in1 = 32'h3C3C_3C3C; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    check_val("mthilo_hi", hi, 32'h3C3C_3C3C);
    check_val("mthilo_lo", lo, 32'h3C3C_3C3C);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("multu_2p32", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("div_m7_2",  2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_7_m2",  2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu_by0",  2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_dist", 2'b11, 32'd20, 32'd6, 32'd2, 32'd3, 1'b1);

    @(posedge clk); #1;
    check_val("idle_after", {31'd0, busy}, 32'd0);

    // Abort a mult partway through with reset
    op = 2'b00; in1 = 32'h0000_1234; in2 = 32'h0000_5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_hi", hi, 32'h0000_0000);
    check_val("abort_lo", lo, 32'h0000_0000);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("post_rst_busy", {31'd0, busy}, 32'd0);
    run_op("multu_6_7", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
